atm_balance_arbiter: RTL and testbench

- Shares one account-balance register among N_ATM ATM controllers.
- Each controller posts a deposit or withdrawal request; the arbiter grants one at a time in round-robin order, applies the arithmetic and returns a one-cycle result.
- Sits between the per-terminal ATM controllers and the account datapath; it is the single owner and writer of the balance.

---
 rtl/atm_balance_arbiter_pkg.sv | 34 +++
 rtl/atm_balance_arbiter_if.sv | 35 +++
 rtl/atm_balance_arbiter_picker.sv | 28 ++
 rtl/atm_balance_arbiter.sv | 139 +++++++++++++
 tb/tb_atm_balance_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_balance_arbiter_pkg.sv
// atm_pkg: shared types and constants for the ATM balance arbiter.
//   state_t  : arbiter FSM states (IDLE, LATCH, EXEC, RESP)
//   trans_t  : transaction type (deposit / withdrawal)
//   MONTO_W, BALANCE_W : amount and balance widths
//   BALANCE_INIT_DEF   : default balance loaded on reset
//   onehot_to_idx      : index of the set bit in a one-hot vector (up to 8 bits)
package atm_pkg;

  localparam int unsigned MONTO_W   = 32;
  localparam int unsigned BALANCE_W = 64;
  localparam logic [BALANCE_W-1:0] BALANCE_INIT_DEF = 64'd4500;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    TRANS_DEPOSITO = 1'b0,
    TRANS_RETIRO   = 1'b1
  } trans_t;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/atm_balance_arbiter_if.sv
// atm_balance_arbiter_if: request/response bundle between the ATM
// controllers (master) and the balance arbiter (slave).
//   req, tipo_trans, monto        : controller -> arbiter
//   grant, done, flags, balance,
//   ocupado                       : arbiter -> controllers
interface atm_balance_arbiter_if #(
  parameter int unsigned N_ATM = 4
);
  import atm_pkg::*;

  logic [N_ATM-1:0]         req;
  logic [N_ATM-1:0]         tipo_trans;
  logic [MONTO_W*N_ATM-1:0] monto;
  logic [N_ATM-1:0]         grant;
  logic [N_ATM-1:0]         done;
  logic                     balance_actualizado;
  logic                     fondos_insuficientes;
  logic                     limite_excedido;
  logic                     desborde;
  logic [BALANCE_W-1:0]     balance;
  logic                     ocupado;

  modport master (
    output req, tipo_trans, monto,
    input  grant, done, balance_actualizado, fondos_insuficientes,
           limite_excedido, desborde, balance, ocupado
  );

  modport slave (
    input  req, tipo_trans, monto,
    output grant, done, balance_actualizado, fondos_insuficientes,
           limite_excedido, desborde, balance, ocupado
  );

endinterface

// File: rtl/atm_balance_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_grant : one-hot winner (first set bit at or after i_ptr, wrapping)
//   o_valid : any request present
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = PTR_W'((32'(i_ptr) + k) % N);
      if (i_req[w_j] && (o_grant == '0)) o_grant[w_j] = 1'b1;
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: single owner of the account balance, serving N_ATM
// controllers one transaction at a time in round-robin order.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : atm_balance_arbiter_if.slave (req/tipo_trans/monto in;
//          grant/done/flags/balance/ocupado out)
// Optional feature: define ATM_WITHDRAW_LIMIT_EN to reject withdrawals
// above MAX_RETIRO with limite_excedido (checked before funds).
module atm_balance_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned           N_ATM        = 4,
  parameter logic [BALANCE_W-1:0]  BALANCE_INIT = BALANCE_INIT_DEF,
  parameter logic [MONTO_W-1:0]    MAX_RETIRO   = 32'd2000
) (
  input logic                  clk,
  input logic                  rst,
  atm_balance_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(N_ATM);

  state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, r_idx, w_pick_idx;
  logic [N_ATM-1:0]     r_winner, w_pick, w_grant, w_done;
  logic                 w_pick_valid;
  trans_t               r_tipo;
  logic [MONTO_W-1:0]   r_monto, w_monto_sel;
  logic [BALANCE_W-1:0] r_balance;
  logic                 r_act, r_insuf, r_lim, r_desb;
  logic [BALANCE_W:0]   w_sum;
  logic                 w_rej_insuf, w_rej_lim;

  rr_priority_picker #(.N(N_ATM), .PTR_W(PTR_W)) u_picker (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_pick_idx = PTR_W'(onehot_to_idx(8'(w_pick)));

  always_comb begin
    w_monto_sel = '0;
    for (int unsigned i = 0; i < N_ATM; i++) begin
      if (r_idx == PTR_W'(i)) w_monto_sel = bus.monto[i*MONTO_W +: MONTO_W];
    end
  end

  // 65-bit sum exposes deposit overflow in its top bit.
  always_comb begin
    w_sum       = {1'b0, r_balance} + (BALANCE_W+1)'(r_monto);
    w_rej_insuf = BALANCE_W'(r_monto) > r_balance;
`ifdef ATM_WITHDRAW_LIMIT_EN
    w_rej_lim   = r_monto > MAX_RETIRO;
`else
    w_rej_lim   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    w_done      = '0;
    case (r_state)
      ST_IDLE:  if (w_pick_valid) w_state_nxt = ST_LATCH;
      ST_LATCH: begin w_grant = r_winner; w_state_nxt = ST_EXEC; end
      ST_EXEC:  begin w_grant = r_winner; w_state_nxt = ST_RESP; end
      ST_RESP:  begin w_grant = r_winner; w_done = r_winner; w_state_nxt = ST_IDLE; end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_balance <= BALANCE_INIT;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_winner  <= '0;
      r_tipo    <= TRANS_DEPOSITO;
      r_monto   <= '0;
      r_act     <= 1'b0;
      r_insuf   <= 1'b0;
      r_lim     <= 1'b0;
      r_desb    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          {r_act, r_insuf, r_lim, r_desb} <= '0;
          if (w_pick_valid) begin
            r_winner <= w_pick;
            r_idx    <= w_pick_idx;
          end
        end
        ST_LATCH: begin
          {r_act, r_insuf, r_lim, r_desb} <= '0;
          r_tipo  <= trans_t'(bus.tipo_trans[r_idx]);
          r_monto <= w_monto_sel;
        end
        ST_EXEC: begin
          if (r_tipo == TRANS_DEPOSITO) begin
            if (w_sum[BALANCE_W]) r_desb <= 1'b1;
            else begin
              r_balance <= w_sum[BALANCE_W-1:0];
              r_act     <= 1'b1;
            end
          end else if (w_rej_lim) begin
            r_lim <= 1'b1;
          end else if (w_rej_insuf) begin
            r_insuf <= 1'b1;
          end else begin
            r_balance <= r_balance - BALANCE_W'(r_monto);
            r_act     <= 1'b1;
          end
        end
        ST_RESP: begin
          {r_act, r_insuf, r_lim, r_desb} <= '0;
          r_ptr <= (r_idx == PTR_W'(N_ATM-1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant                = w_grant;
  assign bus.done                 = w_done;
  assign bus.balance_actualizado  = r_act;
  assign bus.fondos_insuficientes = r_insuf;
  assign bus.limite_excedido      = r_lim;
  assign bus.desborde             = r_desb;
  assign bus.balance              = r_balance;
  assign bus.ocupado              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// tb_atm_balance_arbiter: directed bench for atm_balance_arbiter with a
// transaction-level model (round-robin choice + balance arithmetic) checked
// every cycle, plus literal expectations per transaction. Two instances:
// dut_a with the default initial balance, dut_b preloaded to 2^64-10.
// Expectations follow ATM_WITHDRAW_LIMIT_EN when the bench is built with it.
module tb_atm_balance_arbiter;

  localparam logic [63:0] INIT_A = 64'd4500;
  localparam logic [63:0] INIT_B = 64'hFFFF_FFFF_FFFF_FFF6;
  localparam logic DEP = 1'b0;
  localparam logic RET = 1'b1;
  localparam logic [3:0] F_ACT = 4'b1000, F_INS = 4'b0100, F_LIM = 4'b0010, F_DES = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]   req_v   [2];
  logic [3:0]   tipo_v  [2];
  logic [127:0] monto_v [2];

  logic [3:0]  g_grant [2];
  logic [3:0]  g_done  [2];
  logic [3:0]  g_flags [2];
  logic        g_ocu   [2];
  logic [63:0] g_bal   [2];

  // model state
  logic [63:0] m_bal   [2];
  int          m_ptr   [2];
  logic [3:0]  m_pend  [2];
  logic        m_tipo  [2][4];
  logic [31:0] m_monto [2][4];
  logic [3:0]  cap_flags [2];
  int          order_q [$];

  atm_balance_arbiter_if #(.N_ATM(4)) ifa ();
  atm_balance_arbiter_if #(.N_ATM(4)) ifb ();

  atm_balance_arbiter #(.N_ATM(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  atm_balance_arbiter #(.N_ATM(4), .BALANCE_INIT(INIT_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.req = req_v[0];  assign ifa.tipo_trans = tipo_v[0];  assign ifa.monto = monto_v[0];
  assign ifb.req = req_v[1];  assign ifb.tipo_trans = tipo_v[1];  assign ifb.monto = monto_v[1];

  assign g_grant[0] = ifa.grant;  assign g_done[0] = ifa.done;
  assign g_grant[1] = ifb.grant;  assign g_done[1] = ifb.done;
  assign g_flags[0] = {ifa.balance_actualizado, ifa.fondos_insuficientes, ifa.limite_excedido, ifa.desborde};
  assign g_flags[1] = {ifb.balance_actualizado, ifb.fondos_insuficientes, ifb.limite_excedido, ifb.desborde};
  assign g_ocu[0] = ifa.ocupado;  assign g_bal[0] = ifa.balance;
  assign g_ocu[1] = ifb.ocupado;  assign g_bal[1] = ifb.balance;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic post(input int d, input int w, input logic t, input logic [31:0] m);
    tipo_v[d][w]           = t;
    monto_v[d][w*32 +: 32] = m;
    req_v[d][w]            = 1'b1;
    m_tipo[d][w]           = t;
    m_monto[d][w]          = m;
    m_pend[d][w]           = 1'b1;
  endtask

  task automatic wait_idle(input int d, input int budget, input string nm);
    int n;
    n = 0;
    while (m_pend[d] != 4'b0 && n < budget) begin
      @(negedge clk);
      req_v[d] = req_v[d] & ~g_done[d];
      n++;
    end
    chk({nm, "_timeout"}, 64'(m_pend[d] == 4'b0), 64'd1);
    @(negedge clk);
  endtask

  task automatic txn(input int d, input int w, input logic t, input logic [31:0] m,
                     input logic [63:0] eb, input logic [3:0] ef, input string nm);
    post(d, w, t, m);
    wait_idle(d, 40, nm);
    chk({nm, "_flags"}, 64'(cap_flags[d]), 64'(ef));
    chk({nm, "_bal"}, g_bal[d], eb);
  endtask

  // compare process: model of arbitration order and balance arithmetic
  initial begin
    int w, j;
    logic [64:0] s;
    logic [3:0]  ef;
    logic        lim;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          m_bal[d]  = (d == 0) ? INIT_A : INIT_B;
          m_ptr[d]  = 0;
          m_pend[d] = 4'b0;
          chk("rst_quiet", 64'({g_grant[d], g_done[d], g_flags[d], g_ocu[d]}), 64'd0);
        end else begin
          chk("grant_onehot", 64'($countones(g_grant[d]) <= 1), 64'd1);
          chk("done_in_grant", 64'(g_done[d] & ~g_grant[d]), 64'd0);
          chk("flag_exclusive", 64'($countones(g_flags[d]) <= 1), 64'd1);
          chk("ocupado", 64'(g_ocu[d]), 64'(|g_grant[d]));
          if (g_done[d] == 4'b0) begin
            chk("flags_idle", 64'(g_flags[d]), 64'd0);
          end else begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
              j = (m_ptr[d] + k) % 4;
              if (w < 0 && m_pend[d][j]) w = j;
            end
            if (w < 0) begin
              chk("done_unexpected", 64'(g_done[d]), 64'd0);
            end else begin
              chk("done_winner", 64'(g_done[d]), 64'(4'b0001 << w));
              if (m_tipo[d][w] == DEP) begin
                s = {1'b0, m_bal[d]} + 65'(m_monto[d][w]);
                if (s[64]) ef = F_DES;
                else begin ef = F_ACT; m_bal[d] = s[63:0]; end
              end else begin
                lim = 1'b0;
`ifdef ATM_WITHDRAW_LIMIT_EN
                lim = m_monto[d][w] > 32'd2000;
`endif
                if (lim) ef = F_LIM;
                else if (64'(m_monto[d][w]) > m_bal[d]) ef = F_INS;
                else begin ef = F_ACT; m_bal[d] = m_bal[d] - 64'(m_monto[d][w]); end
              end
              chk("done_flags", 64'(g_flags[d]), 64'(ef));
              cap_flags[d] = g_flags[d];
              m_pend[d][w] = 1'b0;
              m_ptr[d]     = (w + 1) % 4;
              if (d == 0) order_q.push_back(w);
            end
          end
          chk("bal_track", g_bal[d], m_bal[d]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0; tipo_v[d] = '0; monto_v[d] = '0;
      m_bal[d] = (d == 0) ? INIT_A : INIT_B; m_ptr[d] = 0; m_pend[d] = '0;
      cap_flags[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_bal_a", g_bal[0], INIT_A);
    chk("reset_bal_b", g_bal[1], INIT_B);
    chk("reset_outs", 64'({g_grant[0], g_done[0], g_flags[0], g_ocu[0]}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // first deposit: grant one cycle after sampling, done three after
    post(0, 0, DEP, 32'd500);
    @(negedge clk);
    chk("lat_grant_latch", 64'(g_grant[0]), 64'b0001);
    chk("lat_no_done1", 64'(g_done[0]), 64'd0);
    @(negedge clk);
    chk("lat_grant_exec", 64'(g_grant[0]), 64'b0001);
    chk("lat_no_done2", 64'(g_done[0]), 64'd0);
    @(negedge clk);
    chk("lat_done", 64'(g_done[0]), 64'b0001);
    chk("lat_flags", 64'(g_flags[0]), 64'(F_ACT));
    chk("lat_bal", g_bal[0], 64'd5000);
    req_v[0][0] = 1'b0;
    @(negedge clk);
    @(negedge clk);

    txn(0, 1, RET, 32'd500,  64'd4500, F_ACT, "wd500");
    txn(0, 2, RET, 32'd6000, 64'd4500, F_INS, "wd6000_insuf");
    txn(0, 3, RET, 32'd4500, 64'd0,    F_ACT, "wd_exact");
    txn(0, 0, DEP, 32'd4500, 64'd4500, F_ACT, "dep4500");
`ifdef ATM_WITHDRAW_LIMIT_EN
    txn(0, 1, RET, 32'd2500, 64'd4500, F_LIM, "wd2500_limit");
    txn(0, 2, RET, 32'd2000, 64'd2500, F_ACT, "wd2000");
    b = 64'd2500;
`else
    txn(0, 1, RET, 32'd2500, 64'd2000, F_ACT, "wd2500");
    txn(0, 2, RET, 32'd2000, 64'd0,    F_ACT, "wd2000");
    b = 64'd0;
`endif
    txn(0, 3, DEP, 32'd0, b, F_ACT, "dep_zero");

    // all four at once from pointer 0
    order_q.delete();
    for (int i = 0; i < 4; i++) post(0, i, DEP, 32'(i + 1));
    wait_idle(0, 60, "rr4");
    chk("rr4_count", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) chk("rr4_order", 64'(order_q[i]), 64'(i));
    chk("rr4_bal", g_bal[0], b + 64'd10);

    // pointer wrapped to 0: 1 then 3
    order_q.delete();
    post(0, 1, DEP, 32'd100);
    post(0, 3, DEP, 32'd100);
    wait_idle(0, 40, "rr13");
    chk("rr13_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      chk("rr13_first", 64'(order_q[0]), 64'd1);
      chk("rr13_second", 64'(order_q[1]), 64'd3);
    end
    chk("rr13_bal", g_bal[0], b + 64'd210);

    txn(0, 1, DEP, 32'd0, b + 64'd210, F_ACT, "dep_zero_ptr2");

    // reset during EXEC of a withdrawal of 100
    post(0, 2, RET, 32'd100);
    @(negedge clk);
    @(negedge clk);
    chk("exec_grant", 64'(g_grant[0]), 64'b0100);
    rst = 1'b0;
    req_v[0] = '0;
    #1;
    chk("rst_exec_outs", 64'({g_grant[0], g_done[0], g_flags[0], g_ocu[0]}), 64'd0);
    chk("rst_exec_bal", g_bal[0], INIT_A);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    order_q.delete();
    post(0, 1, DEP, 32'd1);
    post(0, 3, DEP, 32'd1);
    wait_idle(0, 40, "post_rst");
    chk("post_rst_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) chk("post_rst_first", 64'(order_q[0]), 64'd1);
    chk("post_rst_bal", g_bal[0], 64'd4502);

    // overflow boundary on the preloaded instance
    txn(1, 0, DEP, 32'd9, 64'hFFFF_FFFF_FFFF_FFFF, F_ACT, "dep_to_max");
    txn(1, 1, DEP, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, F_DES, "dep_overflow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
